// File: rtl/lives_controller.sv
// Game mode and reserve-ship controller with frame-based respawn delay and invulnerability.
// Optional feature: define LIVES_CHEAT_EN to enable the cheat input (refill lives, long invulnerability).
module lives_controller #(
  parameter int START_LIVES   = 3,
  parameter int MAX_RESERVE   = 5,
  parameter int DEATH_FRAMES  = 60,
  parameter int INVULN_FRAMES = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] xCoord,
  input  logic [10:0] yCoord,
  input  logic        start_btn,
  input  logic        hit,
  input  logic        bonus_life,
  input  logic        cheat,
  output logic [1:0]  mode,
  output logic [2:0]  lives,
  output logic        invuln,
  output logic        respawn,
  output logic        game_over
);

  typedef enum logic [1:0] {
    TITLE     = 2'd0,
    RESPAWN   = 2'd1,
    PLAY      = 2'd2,
    GAME_OVER = 2'd3
  } mode_t;

  localparam logic [2:0] START_L  = 3'(START_LIVES - 1);
  localparam logic [2:0] MAX_L    = 3'(MAX_RESERVE);
  localparam logic [7:0] DEATH_L  = 8'(DEATH_FRAMES);
  localparam logic [7:0] INVULN_L = 8'(INVULN_FRAMES);

  mode_t      mode_q, mode_n;
  logic [2:0] lives_q, lives_n, lives_bonus;
  logic [7:0] inv_cnt, inv_n;
  logic [7:0] death_cnt, death_n;
  logic       respawn_n;
  logic       at_origin, at_origin_q, frame_tick;
  logic       start_q, start_press;

  assign at_origin   = (xCoord == 11'd0) && (yCoord == 11'd0);
  assign frame_tick  = at_origin && !at_origin_q;
  assign start_press = start_btn && !start_q;
  assign lives_bonus = (lives_q >= MAX_L) ? MAX_L : lives_q + 3'd1;

`ifdef LIVES_CHEAT_EN
  logic cheat_q, cheat_press;
  assign cheat_press = cheat && !cheat_q;
`else
  logic unused_cheat;
  assign unused_cheat = cheat;
`endif

  // Next-state logic; a bonus in PLAY is applied before the hit sees the count.
  always_comb begin
    mode_n    = mode_q;
    lives_n   = lives_q;
    inv_n     = inv_cnt;
    death_n   = death_cnt;
    respawn_n = 1'b0;
    unique case (mode_q)
      TITLE: begin
        if (start_press) begin
          mode_n  = PLAY;
          lives_n = START_L;
          inv_n   = INVULN_L;
        end
      end
      PLAY: begin
        if (frame_tick && inv_cnt != 8'd0) inv_n = inv_cnt - 8'd1;
        if (bonus_life) lives_n = lives_bonus;
        if (hit && inv_cnt == 8'd0) begin
          if (lives_n == 3'd0) begin
            mode_n = GAME_OVER;
          end else begin
            lives_n = lives_n - 3'd1;
            death_n = DEATH_L;
            mode_n  = RESPAWN;
          end
        end
      end
      RESPAWN: begin
        if (bonus_life) lives_n = lives_bonus;
        if (frame_tick) begin
          death_n = death_cnt - 8'd1;
          if (death_cnt == 8'd1) begin
            mode_n    = PLAY;
            respawn_n = 1'b1;
            inv_n     = INVULN_L;
          end
        end
      end
      GAME_OVER: begin
        if (start_press) begin
          mode_n  = TITLE;
          lives_n = START_L;
        end
      end
    endcase
`ifdef LIVES_CHEAT_EN
    // The cheat overrides any hit taken in the same cycle.
    if (cheat_press && (mode_q == PLAY || mode_q == RESPAWN)) begin
      lives_n = MAX_L;
      inv_n   = 8'hFF;
      if (mode_q == PLAY) begin
        mode_n  = PLAY;
        death_n = death_cnt;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= TITLE;
      lives_q     <= START_L;
      inv_cnt     <= 8'd0;
      death_cnt   <= 8'd0;
      at_origin_q <= 1'b0;
      start_q     <= 1'b0;
      invuln      <= 1'b0;
      respawn     <= 1'b0;
      game_over   <= 1'b0;
`ifdef LIVES_CHEAT_EN
      cheat_q     <= 1'b0;
`endif
    end else begin
      mode_q      <= mode_n;
      lives_q     <= lives_n;
      inv_cnt     <= inv_n;
      death_cnt   <= death_n;
      at_origin_q <= at_origin;
      start_q     <= start_btn;
      invuln      <= (inv_n != 8'd0);
      respawn     <= respawn_n;
      game_over   <= (mode_n == GAME_OVER);
`ifdef LIVES_CHEAT_EN
      cheat_q     <= cheat;
`endif
    end
  end

  assign mode  = mode_q;
  assign lives = lives_q;

endmodule
